identity_sweep_ctrl: RTL and testbench

Sequencer for exhaustive Boolean-identity checking in hardware. Drives an N-variable input vector into a combinational equivalence datapath that produces two outputs (`lhs`, `rhs`), and steps through all 2^N combinations in ascending binary order. It holds each vector for a programmable settle time and compares `lhs` against `rhs`. It reports pass/fail, the mismatch count, and the first failing vector, replacing the per-lab hand-written stimulus sequences with one reusable on-chip controller.

---
 rtl/identity_sweep_ctrl.sv | 105 ++++++++++
 tb/tb_identity_sweep_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/identity_sweep_ctrl.sv
// identity_sweep_ctrl
// Walks an N-variable input vector through all 2^N combinations in ascending
// order. It holds each vector for DWELL cycles, then compares the lhs/rhs
// results of an external combinational datapath. It reports pass, the mismatch
// count and the lowest failing vector, so individual labs do not need their own
// hand-written stimulus sequences.

module identity_sweep_ctrl #(
   parameter int N_VARS = 3,
   parameter int DWELL  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              lhs_in,
   input  logic              rhs_in,
   output logic [N_VARS-1:0] vec_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_VARS:0]   mismatch_cnt,
   output logic [N_VARS-1:0] first_fail_vec,
   output logic              first_fail_valid
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // The dwell counter only has to reach DWELL-1.
   localparam int              CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);
   localparam logic [N_VARS-1:0] VEC_LAST = '1;

   logic [1:0]      state;
   logic [CW-1:0]   dwell_cnt;
   logic            mismatch;
   logic [N_VARS:0] cnt_next;

   assign mismatch = lhs_in ^ rhs_in;
   assign cnt_next = mismatch_cnt + {{N_VARS{1'b0}}, mismatch};

   // Status flags are decoded straight from the state, so they have no extra latency.
   assign busy = (state == ST_HOLD);
   assign done = (state == ST_DONE);

   // Sweep sequencer. In HOLD, abort is checked before the sample edge, so a
   // sample that coincides with an abort is dropped. The increment of the
   // mismatch count cannot overflow because it has one more bit than the vector.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         dwell_cnt        <= '0;
         vec_out          <= '0;
         pass             <= 1'b0;
         mismatch_cnt     <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  vec_out          <= '0;
                  dwell_cnt        <= '0;
                  mismatch_cnt     <= '0;
                  first_fail_valid <= 1'b0;
                  pass             <= 1'b0;
                  state            <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (abort) begin
                  state     <= ST_IDLE;
                  vec_out   <= '0;
                  dwell_cnt <= '0;
                  pass      <= 1'b0;
               end else if (dwell_cnt == DWELL_LAST) begin
                  mismatch_cnt <= cnt_next;
                  if (mismatch && !first_fail_valid) begin
                     first_fail_vec   <= vec_out;
                     first_fail_valid <= 1'b1;
                  end
                  if (vec_out == VEC_LAST) begin
                     state <= ST_DONE;
                     pass  <= (cnt_next == '0);
                  end else begin
                     vec_out   <= vec_out + N_VARS'(1);
                     dwell_cnt <= '0;
                  end
               end else begin
                  dwell_cnt <= dwell_cnt + CW'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_identity_sweep_ctrl.sv
// Testbench for identity_sweep_ctrl: the DUT runs against a datapath with
// fault injection, and the results are compared with a reference computed
// from a per-vector fault mask. A second instance covers N_VARS=2, DWELL=1.

module tb_identity_sweep_ctrl;

   localparam int N  = 3;
   localparam int D  = 2;
   localparam int NV = 1 << N;

   logic          clk = 1'b0;
   logic          rst, start, abort;
   logic          lhs_in, rhs_in;
   logic [N-1:0]  vec_out;
   logic          busy, done, pass;
   logic [N:0]    mismatch_cnt;
   logic [N-1:0]  first_fail_vec;
   logic          first_fail_valid;
   logic [NV-1:0] fault_mask;

   logic          start2, abort2, lhs2, rhs2;
   logic [1:0]    vec2;
   logic          busy2, done2, pass2;
   logic [2:0]    cnt2;
   logic [1:0]    ffvec2;
   logic          ffvalid2;

   int checks = 0;
   int errors = 0;

   identity_sweep_ctrl #(.N_VARS(N), .DWELL(D)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .lhs_in(lhs_in), .rhs_in(rhs_in), .vec_out(vec_out),
      .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
      .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
   );

   identity_sweep_ctrl #(.N_VARS(2), .DWELL(1)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort2),
      .lhs_in(lhs2), .rhs_in(rhs2), .vec_out(vec2),
      .busy(busy2), .done(done2), .pass(pass2), .mismatch_cnt(cnt2),
      .first_fail_vec(ffvec2), .first_fail_valid(ffvalid2)
   );

   always #5 clk = ~clk;

   // Datapath: lhs = x&(y|z). rhs equals lhs except where the fault mask flips it.
   always_comb begin
      lhs_in = vec_out[2] & (vec_out[1] | vec_out[0]);
      rhs_in = lhs_in ^ fault_mask[vec_out];
      lhs2   = vec2[1] | vec2[0];
      rhs2   = vec2[0] | vec2[1];
   end

   // Reference: number of faulty vectors among the first nvec vectors sampled.
   function automatic int ref_count(input logic [NV-1:0] m, input int nvec);
      int n = 0;
      for (int k = 0; k < nvec; k++) if (m[k]) n++;
      return n;
   endfunction

   // Reference: the lowest faulty vector among the first nvec, or -1 if none.
   function automatic int ref_first(input logic [NV-1:0] m, input int nvec);
      for (int k = 0; k < nvec; k++) if (m[k]) return k;
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Run one sweep. abort_at and restart_at are cycle indices after the start edge; -1 disables them.
   task automatic applyStimulus(input logic [NV-1:0] mask, input int abort_at, input int restart_at);
      int c;
      int ac;
      int nf;
      fault_mask = mask;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      c = 0;
      while (busy === 1'b1 && c <= NV*D + 4) begin
         checkOutput("vec_step", 32'(vec_out), 32'(c / D));
         checkOutput("done_low_busy", 32'(done), 32'd0);
         start = (c == restart_at);
         abort = (c == abort_at);
         ac = c;
         @(negedge clk);
         c++;
         if (abort) begin
            abort = 1'b0;
            start = 1'b0;
            nf = ref_first(mask, ac / D);
            checkOutput("abort_busy", 32'(busy), 32'd0);
            checkOutput("abort_vec", 32'(vec_out), 32'd0);
            checkOutput("abort_done", 32'(done), 32'd0);
            checkOutput("abort_pass", 32'(pass), 32'd0);
            checkOutput("abort_cnt", 32'(mismatch_cnt), 32'(ref_count(mask, ac / D)));
            checkOutput("abort_ffv", 32'(first_fail_valid), 32'(nf >= 0));
            if (nf >= 0) checkOutput("abort_ffvec", 32'(first_fail_vec), 32'(nf));
            @(negedge clk);
            checkOutput("abort_no_done", 32'(done), 32'd0);
            return;
         end
      end
      start = 1'b0;
      nf = ref_first(mask, NV);
      checkOutput("busy_len", 32'(c), 32'(NV * D));
      checkOutput("done_pulse", 32'(done), 32'd1);
      checkOutput("pass", 32'(pass), 32'(mask == '0));
      checkOutput("cnt", 32'(mismatch_cnt), 32'(ref_count(mask, NV)));
      checkOutput("ffv", 32'(first_fail_valid), 32'(nf >= 0));
      if (nf >= 0) checkOutput("ffvec", 32'(first_fail_vec), 32'(nf));
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("pass_hold", 32'(pass), 32'(mask == '0));
   endtask

   initial begin
      int c;
      logic [NV-1:0] m;
      int ab;
      rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
      fault_mask = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_vec", 32'(vec_out), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_pass", 32'(pass), 32'd0);
      checkOutput("rst_cnt", 32'(mismatch_cnt), 32'd0);
      checkOutput("rst_ffvec", 32'(first_fail_vec), 32'd0);
      checkOutput("rst_ffv", 32'(first_fail_valid), 32'd0);
      rst = 1'b0;

      // Directed sweeps.
      applyStimulus(8'h00, -1, -1);
      applyStimulus(8'h20, -1, -1);
      applyStimulus(8'hFF, -1, -1);
      applyStimulus(8'h12, 6, -1);
      applyStimulus(8'h00, -1, -1);
      applyStimulus(8'h40, -1, 5);

      // start and abort together in IDLE: start wins.
      fault_mask = '0;
      @(negedge clk); start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      checkOutput("start_abort_busy", 32'(busy), 32'd1);
      checkOutput("start_abort_vec", 32'(vec_out), 32'd0);
      c = 0;
      while (busy === 1'b1 && c < 40) begin @(negedge clk); c++; end
      checkOutput("start_abort_len", 32'(c), 32'(NV * D));
      @(negedge clk);

      // Reset in the middle of a sweep, after a failure has been recorded.
      fault_mask = 8'h01;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("mrst_vec", 32'(vec_out), 32'd0);
      checkOutput("mrst_busy", 32'(busy), 32'd0);
      checkOutput("mrst_done", 32'(done), 32'd0);
      checkOutput("mrst_pass", 32'(pass), 32'd0);
      checkOutput("mrst_cnt", 32'(mismatch_cnt), 32'd0);
      checkOutput("mrst_ffvec", 32'(first_fail_vec), 32'd0);
      checkOutput("mrst_ffv", 32'(first_fail_valid), 32'd0);
      @(negedge clk);
      checkOutput("mrst_idle", 32'(busy), 32'd0);

      // Randomized sweeps, with an occasional abort.
      for (int i = 0; i < 8; i++) begin
         m  = NV'($urandom);
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NV*D - 1)) : -1;
         applyStimulus(m, ab, -1);
      end

      // Second instance: N_VARS=2, DWELL=1, equivalent datapath.
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      c = 0;
      while (busy2 === 1'b1 && c < 10) begin
         checkOutput("d2_vec", 32'(vec2), 32'(c));
         @(negedge clk); c++;
      end
      checkOutput("d2_len", 32'(c), 32'd4);
      checkOutput("d2_done", 32'(done2), 32'd1);
      checkOutput("d2_pass", 32'(pass2), 32'd1);
      checkOutput("d2_cnt", 32'(cnt2), 32'd0);
      checkOutput("d2_ffv", 32'(ffvalid2), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
